cndm_micro_txq_sched: RTL and testbench

//  Round-robin TX queue scheduler for the Corundum-micro port. It tracks per-queue producer (doorbell)
//  and scheduled pointers, plus outstanding descriptors. It issues one queue-index request at a time to
//  the descriptor-read engine, caps in-flight descriptors per queue and retires them on TX completion.

---
 rtl/cndm_micro_pkg.sv | 15 +
 rtl/cndm_micro_txq_rr_arb.sv | 29 ++
 rtl/cndm_micro_txq_sched.sv | 119 +++++++++++
 tb/tb_cndm_micro_txq_sched.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cndm_micro_pkg.sv
// Shared definitions for the Corundum-micro port blocks.
package cndm_micro_pkg;

    localparam int CNDM_PTR_W         = 16;
    localparam int CNDM_QUEUES        = 4;
    localparam int CNDM_MAX_INFLIGHT  = 8;

    typedef logic [$clog2(CNDM_QUEUES)-1:0] cndm_qidx_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } sched_state_t;

endpackage

// File: rtl/cndm_micro_txq_rr_arb.sv
// Circular priority encoder: grants the first requesting index after 'last'.
module cndm_micro_txq_rr_arb #(
    parameter  int QUEUES = 4,
    localparam int QIDX_W = $clog2(QUEUES)
) (
    input  logic [QUEUES-1:0] req,
    input  logic [QIDX_W-1:0] last,
    output logic [QIDX_W-1:0] grant,
    output logic              any
);

    logic [QIDX_W-1:0] idx;

    // NOTE: every output gets a default before the loop so no latch is inferred.
    // Scanning from the farthest offset down lets the nearest requester win.
    always_comb begin
        grant = '0;
        any   = 1'b0;
        idx   = '0;
        for (int i = QUEUES; i >= 1; i--) begin
            idx = QIDX_W'((int'(last) + i) % QUEUES);
            if (req[idx]) begin
                grant = idx;
                any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cndm_micro_txq_sched.sv
// Round-robin TX queue scheduler: doorbell/scheduled pointers, per-queue in-flight cap,
// one descriptor fetch request outstanding at a time.
module cndm_micro_txq_sched
    import cndm_micro_pkg::*;
#(
    parameter  int QUEUES       = CNDM_QUEUES,
    parameter  int PTR_W        = CNDM_PTR_W,
    parameter  int MAX_INFLIGHT = CNDM_MAX_INFLIGHT,
    localparam int QIDX_W       = $clog2(QUEUES),
    localparam int INFL_W       = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [QUEUES-1:0] cfg_en,
    input  logic              db_valid,
    input  logic [QIDX_W-1:0] db_qidx,
    input  logic [PTR_W-1:0]  db_prod,
    output logic              req_valid,
    input  logic              req_ready,
    output logic [QIDX_W-1:0] req_qidx,
    output logic [PTR_W-1:0]  req_ptr,
    input  logic              cpl_valid,
    input  logic [QIDX_W-1:0] cpl_qidx,
    output logic [QUEUES-1:0] q_busy,
    output logic              cpl_err
);

    sched_state_t      state, state_nxt;
    logic [PTR_W-1:0]  prod     [QUEUES];
    logic [PTR_W-1:0]  sptr     [QUEUES];
    logic [INFL_W-1:0] infl     [QUEUES];
    logic [PTR_W-1:0]  prod_nxt [QUEUES];
    logic [PTR_W-1:0]  sptr_nxt [QUEUES];
    logic [INFL_W-1:0] infl_nxt [QUEUES];
    logic [QUEUES-1:0] eligible, busy_nxt;
    logic [QIDX_W-1:0] rr_last, arb_idx;
    logic              arb_any, hs;

    assign req_valid = (state == ST_REQ);
    assign hs        = req_valid && req_ready;

    always_comb begin
        for (int q = 0; q < QUEUES; q++) begin
            eligible[q] = cfg_en[q] && (prod[q] != sptr[q]) &&
                          (infl[q] < INFL_W'(MAX_INFLIGHT));
        end
    end

    cndm_micro_txq_rr_arb #(.QUEUES(QUEUES)) u_arb (
        .req   (eligible),
        .last  (rr_last),
        .grant (arb_idx),
        .any   (arb_any)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (arb_any) state_nxt = ST_REQ;
            ST_REQ:  if (req_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // A doorbell on a disabled queue re-initialises the ring and overrides a same-cycle grant.
    always_comb begin
        for (int q = 0; q < QUEUES; q++) begin
            logic hs_q, cpl_q, db_q;
            hs_q  = hs && (req_qidx == QIDX_W'(q));
            db_q  = db_valid && (db_qidx == QIDX_W'(q));
            cpl_q = cpl_valid && (cpl_qidx == QIDX_W'(q)) && (infl[q] != '0);

            prod_nxt[q] = db_q ? db_prod : prod[q];
            sptr_nxt[q] = hs_q ? sptr[q] + PTR_W'(1) : sptr[q];
            if (db_q && !cfg_en[q]) sptr_nxt[q] = db_prod;

            infl_nxt[q] = infl[q];
            if (hs_q && !cpl_q)      infl_nxt[q] = infl[q] + INFL_W'(1);
            else if (cpl_q && !hs_q) infl_nxt[q] = infl[q] - INFL_W'(1);

            busy_nxt[q] = (infl_nxt[q] != '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // NOTE: the per-queue arrays are small flop arrays, not RAM, so they take the async reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int q = 0; q < QUEUES; q++) begin
                prod[q] <= '0;
                sptr[q] <= '0;
                infl[q] <= '0;
            end
            rr_last  <= QIDX_W'(QUEUES - 1);
            req_qidx <= '0;
            req_ptr  <= '0;
            q_busy   <= '0;
            cpl_err  <= 1'b0;
        end else begin
            for (int q = 0; q < QUEUES; q++) begin
                prod[q] <= prod_nxt[q];
                sptr[q] <= sptr_nxt[q];
                infl[q] <= infl_nxt[q];
            end
            q_busy  <= busy_nxt;
            cpl_err <= cpl_valid && (infl[cpl_qidx] == '0);
            if (state == ST_IDLE && arb_any) begin
                req_qidx <= arb_idx;
                req_ptr  <= sptr[arb_idx];
            end
            if (hs) rr_last <= req_qidx;
        end
    end

endmodule

// File: tb/tb_cndm_micro_txq_sched.sv
// Self-checking bench for cndm_micro_txq_sched: directed scenarios plus a randomized phase,
// all compared cycle by cycle against a transaction-level reference model.
module tb_cndm_micro_txq_sched;
    import cndm_micro_pkg::*;

    localparam int Q   = 4;
    localparam int MAXI = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   cfg_en = '0;
    logic         db_valid = 1'b0;
    cndm_qidx_t   db_qidx = '0;
    logic [15:0]  db_prod = '0;
    logic         req_valid;
    logic         req_ready = 1'b0;
    cndm_qidx_t   req_qidx;
    logic [15:0]  req_ptr;
    logic         cpl_valid = 1'b0;
    cndm_qidx_t   cpl_qidx = '0;
    logic [3:0]   q_busy;
    logic         cpl_err;

    cndm_micro_txq_sched dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_en    (cfg_en),
        .db_valid  (db_valid),
        .db_qidx   (db_qidx),
        .db_prod   (db_prod),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_qidx  (req_qidx),
        .req_ptr   (req_ptr),
        .cpl_valid (cpl_valid),
        .cpl_qidx  (cpl_qidx),
        .q_busy    (q_busy),
        .cpl_err   (cpl_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: ring pointers, outstanding descriptors, pending request.
    int  m_prod [Q];
    int  m_sptr [Q];
    int  m_infl [Q];
    int  m_rr;
    bit  m_req;
    int  m_qidx, m_ptr;
    bit  m_err;

    int  grants;
    int  g_q [$];
    int  g_p [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int q = 0; q < Q; q++) begin
            m_prod[q] = 0; m_sptr[q] = 0; m_infl[q] = 0;
        end
        m_rr = Q - 1; m_req = 0; m_qidx = 0; m_ptr = 0; m_err = 0;
    endtask

    function automatic bit m_eligible(int q);
        return cfg_en[q] && (m_prod[q] != m_sptr[q]) && (m_infl[q] < MAXI);
    endfunction

    // One clock: advance the model with the inputs as presented, then compare after the edge.
    task automatic tick();
        int  n_prod [Q];
        int  n_sptr [Q];
        int  n_infl [Q];
        bit  hs, took;
        logic [3:0] exp_busy;
        if (req_valid === 1'b1 && req_ready) begin
            grants++;
            g_q.push_back(int'(req_qidx));
            g_p.push_back(int'(req_ptr));
        end
        hs = m_req && req_ready;
        for (int q = 0; q < Q; q++) begin
            bit hq, dq, cq;
            hq = hs && (m_qidx == q);
            dq = db_valid && (int'(db_qidx) == q);
            cq = cpl_valid && (int'(cpl_qidx) == q) && (m_infl[q] > 0);
            n_prod[q] = dq ? int'(db_prod) : m_prod[q];
            n_sptr[q] = hq ? (m_sptr[q] + 1) % 65536 : m_sptr[q];
            if (dq && !cfg_en[q]) n_sptr[q] = int'(db_prod);
            n_infl[q] = m_infl[q] + (hq ? 1 : 0) - (cq ? 1 : 0);
        end
        m_err = cpl_valid && (m_infl[int'(cpl_qidx)] == 0);
        if (!m_req) begin
            took = 0;
            for (int k = 1; k <= Q; k++) begin
                int q;
                q = (m_rr + k) % Q;
                if (!took && m_eligible(q)) begin
                    took = 1; m_req = 1; m_qidx = q; m_ptr = m_sptr[q];
                end
            end
        end else if (hs) begin
            m_req = 0;
            m_rr  = m_qidx;
        end
        for (int q = 0; q < Q; q++) begin
            m_prod[q] = n_prod[q]; m_sptr[q] = n_sptr[q]; m_infl[q] = n_infl[q];
            exp_busy[q] = (n_infl[q] != 0);
        end
        @(posedge clk);
        #1;
        check("req_valid", 32'(req_valid), 32'(m_req));
        if (m_req) begin
            check("req_qidx", 32'(req_qidx), 32'(m_qidx));
            check("req_ptr", 32'(req_ptr), 32'(m_ptr));
        end
        check("q_busy", 32'(q_busy), 32'(exp_busy));
        check("cpl_err", 32'(cpl_err), 32'(m_err));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic doorbell(input int q, input int p);
        db_valid = 1'b1; db_qidx = cndm_qidx_t'(q); db_prod = 16'(p);
        tick();
        db_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        db_valid = 1'b0; cpl_valid = 1'b0; req_ready = 1'b0; cfg_en = '0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_req_valid", 32'(req_valid), 32'd0);
        check("rst_req_qidx", 32'(req_qidx), 32'd0);
        check("rst_req_ptr", 32'(req_ptr), 32'd0);
        check("rst_q_busy", 32'(q_busy), 32'd0);
        check("rst_cpl_err", 32'(cpl_err), 32'd0);
        rst_n = 1'b1;
        grants = 0;
        g_q.delete();
        g_p.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  cap_q;
        logic [15:0] cap_p;
        int          exp_order [8];
        int          exp_ptrs [3];
        model_reset();
        grants = 0;

        // 1: single queue, three descriptors
        do_reset();
        cfg_en = 4'b0001; req_ready = 1'b1;
        doorbell(0, 3);
        run(10);
        check("t1_grants", 32'(grants), 32'd3);
        for (int i = 0; i < 3 && i < g_p.size(); i++) check("t1_ptr", 32'(g_p[i]), 32'(i));
        check("t1_busy0", 32'(q_busy[0]), 32'd1);

        // 2: four queues, round-robin order
        do_reset();
        cfg_en = 4'b1111; req_ready = 1'b1;
        for (int q = 0; q < Q; q++) doorbell(q, 2);
        run(20);
        check("t2_grants", 32'(grants), 32'd8);
        exp_order = '{0, 1, 2, 3, 0, 1, 2, 3};
        for (int i = 0; i < 8 && i < g_q.size(); i++) check("t2_order", 32'(g_q[i]), 32'(exp_order[i]));

        // 3: in-flight cap
        do_reset();
        cfg_en = 4'b0010; req_ready = 1'b1;
        doorbell(1, 20);
        run(40);
        check("t3_cap", 32'(grants), 32'd8);
        cpl_valid = 1'b1; cpl_qidx = 2'd1;
        tick();
        cpl_valid = 1'b0;
        run(10);
        check("t3_after_cpl", 32'(grants), 32'd9);

        // 4: pointer wrap after disabled-queue ring re-init
        do_reset();
        req_ready = 1'b1;
        doorbell(2, 16'hFFFE);
        cfg_en = 4'b0100;
        doorbell(2, 16'h0001);
        run(12);
        check("t4_grants", 32'(grants), 32'd3);
        exp_ptrs = '{32'hFFFE, 32'hFFFF, 32'h0000};
        for (int i = 0; i < 3 && i < g_p.size(); i++) check("t4_ptr", 32'(g_p[i]), 32'(exp_ptrs[i]));

        // 5: backpressure hold, enable dropped, then grant; completion underflow
        do_reset();
        cfg_en = 4'b0001; req_ready = 1'b0;
        doorbell(0, 5);
        run(2);
        check("t5_pending", 32'(req_valid), 32'd1);
        cap_q = req_qidx; cap_p = req_ptr;
        cfg_en = 4'b0000;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t5_hold_valid", 32'(req_valid), 32'd1);
            check("t5_hold_qidx", 32'(req_qidx), 32'(cap_q));
            check("t5_hold_ptr", 32'(req_ptr), 32'(cap_p));
        end
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        run(2);
        check("t5_grant", 32'(grants), 32'd1);
        cpl_valid = 1'b1; cpl_qidx = 2'd3;
        tick();
        cpl_valid = 1'b0;
        check("t5_err_pulse", 32'(cpl_err), 32'd1);
        tick();
        check("t5_err_clear", 32'(cpl_err), 32'd0);
        check("t5_busy", 32'(q_busy), 32'd1);

        // 6: asynchronous reset while a request is pending
        do_reset();
        cfg_en = 4'b0001; req_ready = 1'b0;
        doorbell(0, 2);
        run(2);
        check("t6_pending", 32'(req_valid), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_async_drop", 32'(req_valid), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        grants = 0; g_q.delete(); g_p.delete();
        cfg_en = 4'b0001; req_ready = 1'b1;
        doorbell(0, 1);
        run(4);
        check("t6_grants", 32'(grants), 32'd1);
        if (g_q.size() > 0) begin
            check("t6_first_q", 32'(g_q[0]), 32'd0);
            check("t6_first_ptr", 32'(g_p[0]), 32'd0);
        end

        // Randomized traffic against the model
        do_reset();
        cfg_en = 4'b1111;
        for (int i = 0; i < 600; i++) begin
            int q;
            if ($urandom_range(0, 15) == 0) cfg_en = 4'($urandom);
            db_valid = ($urandom_range(0, 3) == 0);
            q = int'($urandom_range(0, Q - 1));
            db_qidx = cndm_qidx_t'(q);
            db_prod = 16'(m_sptr[q] + int'($urandom_range(0, 6)));
            req_ready = ($urandom_range(0, 2) != 0);
            q = int'($urandom_range(0, Q - 1));
            cpl_qidx = cndm_qidx_t'(q);
            if (m_infl[q] > 0) cpl_valid = ($urandom_range(0, 1) == 1);
            else cpl_valid = ($urandom_range(0, 19) == 0) && !(m_req && m_qidx == q);
            tick();
        end
        db_valid = 1'b0; cpl_valid = 1'b0;
        check("rand_activity", 32'(grants > 20), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
